wb_regfile: RTL and testbench
=============================

Name: wb_regfile

Overview:
- Consumer end of the MEM/WB pipeline register: the write-back stage and the architectural register file it writes.
- Selects write-back data from the MEM/WB outputs and commits it to a 32-entry register file.
- Serves two combinational read ports to the ID stage, with write-to-read bypass in the same cycle.
- Exposes the write-back value for the forwarding unit, plus a retired-write counter for debug and performance.

Parameters:
- DATA_WIDTH, 32, width of each register and of all data buses.
- ADDR_WIDTH, 5, register index width; the register count is 2^ADDR_WIDTH.
- CNT_WIDTH, 32, width of the retired-write counter.

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- MemToReg_in  input  1  from MEM/WB; 1 selects Read_Data_in, 0 selects ALU_Results_in.
- RegWrite_in  input  1  from MEM/WB; write enable for this write-back.
- Read_Data_in  input  DATA_WIDTH  load data from MEM/WB.
- ALU_Results_in  input  DATA_WIDTH  ALU result from MEM/WB.
- Write_reg_num  input  ADDR_WIDTH  destination register index from MEM/WB.
- Rs1  input  ADDR_WIDTH  read port 1 index (ID stage).
- Rs2  input  ADDR_WIDTH  read port 2 index (ID stage).
- Read_data1  output  DATA_WIDTH  read port 1 data.
- Read_data2  output  DATA_WIDTH  read port 2 data.
- WB_data  output  DATA_WIDTH  selected write-back value, for the forwarding unit.
- WB_valid  output  1  high when this cycle performs a real register write.
- wb_count  output  CNT_WIDTH  number of committed register writes.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high.
- Reset values: while reset is high, all registers are forced to 0 and wb_count to 0, immediately and without waiting for a clock edge. Read_data1 and Read_data2 therefore read 0. WB_data and WB_valid are combinational from their inputs and are not affected by reset.
- Reset mid-operation:
  - No register or counter update occurs on any rising edge while reset is high.
  - Deassertion takes effect at the next rising edge.
  - A write pending at deassertion is committed only if RegWrite_in is still high at that edge.
- Write-back select (combinational): WB_data = MemToReg_in ? Read_Data_in : ALU_Results_in.
- WB_valid (combinational) = RegWrite_in AND (Write_reg_num != 0).
- Commit: on the rising edge with reset low and WB_valid=1, regs[Write_reg_num] <= WB_data and wb_count <= wb_count + 1. The counter wraps modulo 2^CNT_WIDTH; all-ones + 1 gives 0.
- Register x0: hardwired to zero.
  - Writes to index 0 are discarded and do not increment wb_count.
  - Reads of index 0 always return 0, with no bypass.
- Reads: combinational, zero latency.
  - Read_dataN = bypass value if WB_valid=1 and RsN == Write_reg_num; otherwise regs[RsN].
  - Bypass value is WB_data, so an instruction in ID sees a write-back committed in the same cycle. This is write-before-read semantics and removes the 3-cycle RAW hazard case.
- Simultaneous events:
  - Rs1 == Rs2 == Write_reg_num: both ports return WB_data.
  - Read and write to different indices: the read returns the stored value; the new value is visible from the next cycle onward through the array.
- RegWrite_in=0: no state change; MemToReg_in is don't-care for state, but WB_data still reflects the mux.
- Latency: WB_data and WB_valid are 0 cycles from the inputs. Array contents and wb_count update at the edge after the inputs are presented. MEM/WB output to architectural state is 1 edge.

Test Plan:
1. Reset: pulse reset asynchronously between edges with Rs1=5, Rs2=31 after prior writes -> Read_data1=Read_data2=0 and wb_count=0 immediately, before any clk edge.
2. ALU write-back: RegWrite_in=1, MemToReg_in=0, ALU_Results_in=32'h0000_1234, Write_reg_num=7, clock once; then RegWrite_in=0, Rs1=7 -> Read_data1=32'h0000_1234, wb_count=1.
3. Load write-back with same-cycle bypass: RegWrite_in=1, MemToReg_in=1, Read_Data_in=32'hDEAD_BEEF, ALU_Results_in=32'h1, Write_reg_num=9, Rs1=9, Rs2=9 before the edge -> Read_data1=Read_data2=WB_data=32'hDEAD_BEEF, WB_valid=1; after the edge the stored reg 9 also equals 32'hDEAD_BEEF.
4. x0 protection: RegWrite_in=1, Write_reg_num=0, ALU_Results_in=32'hFFFF_FFFF, Rs1=0 -> WB_valid=0, Read_data1=0 before and after the edge, wb_count unchanged.
5. Disabled write: RegWrite_in=0, Write_reg_num=7, ALU_Results_in=32'h5555_5555 over 3 edges -> reg 7 keeps its prior value 32'h0000_1234, wb_count unchanged.
6. Counter wrap and reset-during-write: force wb_count near wrap with CNT_WIDTH=4 by doing 16 valid writes -> wb_count=0. Then assert reset during a valid write to reg 3 with value 32'hA5 -> after release, reg 3=0 and wb_count=0.

Source files
------------

// File: rtl/wb_regfile.sv
// Write-back stage and 2^ADDR_WIDTH-entry architectural register file.
// Two combinational read ports with same-cycle write bypass and a retired-write counter.
module wb_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  MemToReg_in,
  input  logic                  RegWrite_in,
  input  logic [DATA_WIDTH-1:0] Read_Data_in,
  input  logic [DATA_WIDTH-1:0] ALU_Results_in,
  input  logic [ADDR_WIDTH-1:0] Write_reg_num,
  input  logic [ADDR_WIDTH-1:0] Rs1,
  input  logic [ADDR_WIDTH-1:0] Rs2,
  output logic [DATA_WIDTH-1:0] Read_data1,
  output logic [DATA_WIDTH-1:0] Read_data2,
  output logic [DATA_WIDTH-1:0] WB_data,
  output logic                  WB_valid,
  output logic [CNT_WIDTH-1:0]  wb_count
);

  localparam int NUM_REGS = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic [CNT_WIDTH-1:0]  cnt_d;
  logic [DATA_WIDTH-1:0] wb_data_s;
  logic                  wb_valid_s;

  // Write-back mux and write qualification; index 0 never counts as a write.
  always_comb begin
    wb_data_s  = MemToReg_in ? Read_Data_in : ALU_Results_in;
    wb_valid_s = RegWrite_in && (Write_reg_num != {ADDR_WIDTH{1'b0}});
  end

  // Next-state for the array and the retired-write counter.
  always_comb begin
    regs_d = regs_q;
    cnt_d  = cnt_q;
    if (wb_valid_s) begin
      regs_d[Write_reg_num] = wb_data_s;
      cnt_d                 = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
    regs_d[0] = {DATA_WIDTH{1'b0}};
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= {DATA_WIDTH{1'b0}};
      end
      cnt_q <= {CNT_WIDTH{1'b0}};
    end else begin
      regs_q <= regs_d;
      cnt_q  <= cnt_d;
    end
  end

  // Read ports: x0 reads zero, otherwise a matching write-back wins over the array.
  always_comb begin
    if (Rs1 == {ADDR_WIDTH{1'b0}}) begin
      Read_data1 = {DATA_WIDTH{1'b0}};
    end else if (wb_valid_s && (Rs1 == Write_reg_num)) begin
      Read_data1 = wb_data_s;
    end else begin
      Read_data1 = regs_q[Rs1];
    end
    if (Rs2 == {ADDR_WIDTH{1'b0}}) begin
      Read_data2 = {DATA_WIDTH{1'b0}};
    end else if (wb_valid_s && (Rs2 == Write_reg_num)) begin
      Read_data2 = wb_data_s;
    end else begin
      Read_data2 = regs_q[Rs2];
    end
  end

  assign WB_data  = wb_data_s;
  assign WB_valid = wb_valid_s;
  assign wb_count = cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile, built with a 4-bit counter to reach wrap quickly.
module tb_wb_regfile;

  logic        clk;
  logic        reset;
  logic        MemToReg_in;
  logic        RegWrite_in;
  logic [31:0] Read_Data_in;
  logic [31:0] ALU_Results_in;
  logic [4:0]  Write_reg_num;
  logic [4:0]  Rs1;
  logic [4:0]  Rs2;
  logic [31:0] Read_data1;
  logic [31:0] Read_data2;
  logic [31:0] WB_data;
  logic        WB_valid;
  logic [3:0]  wb_count;

  int tests_run;
  int tests_failed;

  wb_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .CNT_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .MemToReg_in(MemToReg_in), .RegWrite_in(RegWrite_in),
    .Read_Data_in(Read_Data_in), .ALU_Results_in(ALU_Results_in),
    .Write_reg_num(Write_reg_num), .Rs1(Rs1), .Rs2(Rs2),
    .Read_data1(Read_data1), .Read_data2(Read_data2),
    .WB_data(WB_data), .WB_valid(WB_valid), .wb_count(wb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; MemToReg_in = 1'b0; RegWrite_in = 1'b0;
    Read_Data_in = 32'h0; ALU_Results_in = 32'h0; Write_reg_num = 5'd0;
    Rs1 = 5'd5; Rs2 = 5'd31;
    #12;
    tests_run++;
    if (Read_data1 !== 32'h0) begin tests_failed++; $display("FAIL reset_rd1: got %h expected %h", Read_data1, 32'h0); end
    tests_run++;
    if (Read_data2 !== 32'h0) begin tests_failed++; $display("FAIL reset_rd2: got %h expected %h", Read_data2, 32'h0); end
    tests_run++;
    if (wb_count !== 4'd0) begin tests_failed++; $display("FAIL reset_cnt: got %0d expected %0d", wb_count, 0); end
    reset = 1'b0;
  endtask

  task automatic test_alu_wb();
    RegWrite_in = 1'b1; MemToReg_in = 1'b0; ALU_Results_in = 32'h0000_1234;
    Read_Data_in = 32'hCAFE_0000; Write_reg_num = 5'd7; Rs1 = 5'd1; Rs2 = 5'd2;
    #1;
    tests_run++;
    if (WB_data !== 32'h0000_1234) begin tests_failed++; $display("FAIL alu_wbdata: got %h expected %h", WB_data, 32'h0000_1234); end
    tick();
    RegWrite_in = 1'b0; Rs1 = 5'd7;
    #1;
    tests_run++;
    if (Read_data1 !== 32'h0000_1234) begin tests_failed++; $display("FAIL alu_rd1: got %h expected %h", Read_data1, 32'h0000_1234); end
    tests_run++;
    if (wb_count !== 4'd1) begin tests_failed++; $display("FAIL alu_cnt: got %0d expected %0d", wb_count, 1); end
  endtask

  task automatic test_load_bypass();
    RegWrite_in = 1'b1; MemToReg_in = 1'b1; Read_Data_in = 32'hDEAD_BEEF;
    ALU_Results_in = 32'h1; Write_reg_num = 5'd9; Rs1 = 5'd9; Rs2 = 5'd9;
    #1;
    tests_run++;
    if (Read_data1 !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL bypass_rd1: got %h expected %h", Read_data1, 32'hDEAD_BEEF); end
    tests_run++;
    if (Read_data2 !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL bypass_rd2: got %h expected %h", Read_data2, 32'hDEAD_BEEF); end
    tests_run++;
    if (WB_data !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL bypass_wbdata: got %h expected %h", WB_data, 32'hDEAD_BEEF); end
    tests_run++;
    if (WB_valid !== 1'b1) begin tests_failed++; $display("FAIL bypass_valid: got %b expected %b", WB_valid, 1'b1); end
    tick();
    RegWrite_in = 1'b0;
    #1;
    tests_run++;
    if (Read_data1 !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL load_stored: got %h expected %h", Read_data1, 32'hDEAD_BEEF); end
    tests_run++;
    if (wb_count !== 4'd2) begin tests_failed++; $display("FAIL load_cnt: got %0d expected %0d", wb_count, 2); end
  endtask

  task automatic test_x0();
    RegWrite_in = 1'b1; MemToReg_in = 1'b0; ALU_Results_in = 32'hFFFF_FFFF;
    Write_reg_num = 5'd0; Rs1 = 5'd0; Rs2 = 5'd9;
    #1;
    tests_run++;
    if (WB_valid !== 1'b0) begin tests_failed++; $display("FAIL x0_valid: got %b expected %b", WB_valid, 1'b0); end
    tests_run++;
    if (Read_data1 !== 32'h0) begin tests_failed++; $display("FAIL x0_rd_before: got %h expected %h", Read_data1, 32'h0); end
    tick();
    RegWrite_in = 1'b0;
    #1;
    tests_run++;
    if (Read_data1 !== 32'h0) begin tests_failed++; $display("FAIL x0_rd_after: got %h expected %h", Read_data1, 32'h0); end
    tests_run++;
    if (wb_count !== 4'd2) begin tests_failed++; $display("FAIL x0_cnt: got %0d expected %0d", wb_count, 2); end
  endtask

  task automatic test_disabled_write();
    RegWrite_in = 1'b0; MemToReg_in = 1'b0; ALU_Results_in = 32'h5555_5555;
    Write_reg_num = 5'd7; Rs1 = 5'd7;
    #1;
    tests_run++;
    if (WB_data !== 32'h5555_5555) begin tests_failed++; $display("FAIL dis_wbdata: got %h expected %h", WB_data, 32'h5555_5555); end
    tests_run++;
    if (Read_data1 !== 32'h0000_1234) begin tests_failed++; $display("FAIL dis_nobypass: got %h expected %h", Read_data1, 32'h0000_1234); end
    for (int i = 0; i < 3; i++) tick();
    tests_run++;
    if (Read_data1 !== 32'h0000_1234) begin tests_failed++; $display("FAIL dis_reg7: got %h expected %h", Read_data1, 32'h0000_1234); end
    tests_run++;
    if (wb_count !== 4'd2) begin tests_failed++; $display("FAIL dis_cnt: got %0d expected %0d", wb_count, 2); end
  endtask

  task automatic test_different_index();
    RegWrite_in = 1'b1; MemToReg_in = 1'b0; ALU_Results_in = 32'h0BAD_F00D;
    Write_reg_num = 5'd10; Rs1 = 5'd7; Rs2 = 5'd10;
    #1;
    tests_run++;
    if (Read_data1 !== 32'h0000_1234) begin tests_failed++; $display("FAIL diff_rd1: got %h expected %h", Read_data1, 32'h0000_1234); end
    tick();
    RegWrite_in = 1'b0; Rs1 = 5'd10;
    #1;
    tests_run++;
    if (Read_data1 !== 32'h0BAD_F00D) begin tests_failed++; $display("FAIL diff_next: got %h expected %h", Read_data1, 32'h0BAD_F00D); end
  endtask

  task automatic test_async_reset();
    RegWrite_in = 1'b1; MemToReg_in = 1'b0; ALU_Results_in = 32'h0000_55AA; Write_reg_num = 5'd5;
    tick();
    ALU_Results_in = 32'h0000_0031; Write_reg_num = 5'd31;
    tick();
    RegWrite_in = 1'b0; Rs1 = 5'd5; Rs2 = 5'd31;
    #1;
    tests_run++;
    if (Read_data2 !== 32'h0000_0031) begin tests_failed++; $display("FAIL pre_reset_rd2: got %h expected %h", Read_data2, 32'h0000_0031); end
    #1;
    reset = 1'b1;
    #1;
    tests_run++;
    if (Read_data1 !== 32'h0) begin tests_failed++; $display("FAIL areset_rd1: got %h expected %h", Read_data1, 32'h0); end
    tests_run++;
    if (Read_data2 !== 32'h0) begin tests_failed++; $display("FAIL areset_rd2: got %h expected %h", Read_data2, 32'h0); end
    tests_run++;
    if (wb_count !== 4'd0) begin tests_failed++; $display("FAIL areset_cnt: got %0d expected %0d", wb_count, 0); end
    reset = 1'b0;
  endtask

  task automatic test_counter_wrap();
    MemToReg_in = 1'b0; RegWrite_in = 1'b1;
    for (int i = 0; i < 15; i++) begin
      Write_reg_num = 5'(i + 1);
      ALU_Results_in = 32'h100 + 32'(i);
      tick();
    end
    tests_run++;
    if (wb_count !== 4'd15) begin tests_failed++; $display("FAIL wrap_15: got %0d expected %0d", wb_count, 15); end
    Write_reg_num = 5'd20; ALU_Results_in = 32'h0000_0200;
    tick();
    RegWrite_in = 1'b0;
    tests_run++;
    if (wb_count !== 4'd0) begin tests_failed++; $display("FAIL wrap_0: got %0d expected %0d", wb_count, 0); end
  endtask

  task automatic test_reset_during_write();
    Rs1 = 5'd3; Rs2 = 5'd20;
    #1;
    tests_run++;
    if (Read_data1 !== 32'h0000_0102) begin tests_failed++; $display("FAIL rdw_pre_reg3: got %h expected %h", Read_data1, 32'h0000_0102); end
    RegWrite_in = 1'b1; MemToReg_in = 1'b0; ALU_Results_in = 32'h0000_00A5; Write_reg_num = 5'd3;
    reset = 1'b1;
    tick();
    tick();
    RegWrite_in = 1'b0;
    reset = 1'b0;
    #1;
    tests_run++;
    if (Read_data1 !== 32'h0) begin tests_failed++; $display("FAIL rdw_reg3: got %h expected %h", Read_data1, 32'h0); end
    tests_run++;
    if (wb_count !== 4'd0) begin tests_failed++; $display("FAIL rdw_cnt: got %0d expected %0d", wb_count, 0); end
    tick();
    tests_run++;
    if (Read_data2 !== 32'h0) begin tests_failed++; $display("FAIL rdw_reg20: got %h expected %h", Read_data2, 32'h0); end
  endtask

  task automatic test_back_to_back();
    RegWrite_in = 1'b1; MemToReg_in = 1'b1; Read_Data_in = 32'h1111_0001; Write_reg_num = 5'd12;
    tick();
    Read_Data_in = 32'h2222_0002; Write_reg_num = 5'd13; Rs1 = 5'd12; Rs2 = 5'd13;
    #1;
    tests_run++;
    if (Read_data1 !== 32'h1111_0001) begin tests_failed++; $display("FAIL b2b_rd1: got %h expected %h", Read_data1, 32'h1111_0001); end
    tests_run++;
    if (Read_data2 !== 32'h2222_0002) begin tests_failed++; $display("FAIL b2b_rd2: got %h expected %h", Read_data2, 32'h2222_0002); end
    tick();
    RegWrite_in = 1'b0;
    #1;
    tests_run++;
    if (wb_count !== 4'd2) begin tests_failed++; $display("FAIL b2b_cnt: got %0d expected %0d", wb_count, 2); end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_alu_wb();
    test_load_bypass();
    test_x0();
    test_disabled_write();
    test_different_index();
    test_async_reset();
    test_counter_wrap();
    test_reset_during_write();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
